// File: rtl/multi_oneshot.sv
// multi_oneshot: N-channel synchronise -> debounce -> edge-qualified one-shot pulse.
// Ports: clk, rst (async high), in[N] raw inputs, mode[2] edge select,
//   level[N] debounced level, pulse[N] registered one-shot, any_pulse = |pulse.
// Optional auto-repeat while held: define MULTI_ONESHOT_REPEAT_EN.
module multi_oneshot #(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 4,
  parameter int PULSE_LEN     = 1,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [1:0]   mode,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic {IDLE, ACTIVE} st_e;

  if (N < 1 || SYNC_STAGES < 2 || DEB_CYCLES < 1 || PULSE_LEN < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("multi_oneshot: illegal parameter value");
  end

  logic [N-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N-1:0]                  s;
  logic [N-1:0]                  level_q, level_d;
  logic [N-1:0][DW-1:0]          cnt_q, cnt_d;
  logic [N-1:0]                  rise, fall;
  logic [N-1:0]                  rep_ev;
  logic [N-1:0]                  qev;
  st_e                           state_q [N];
  st_e                           state_d [N];
  logic [N-1:0][PW-1:0]          pcnt_q, pcnt_d;
  logic [N-1:0]                  pulse_q, pulse_d;
  logic                          any_q, any_d;

  // Synchroniser shift and debounce counter
  always_comb begin
    sync_d  = sync_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    s       = '0;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < N; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], in[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        rise[i]    = s[i];
        fall[i]    = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef MULTI_ONESHOT_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                      : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [N-1:0][RW-1:0] rcnt_q, rcnt_d;
  // rarm: first repeat already fired, so the period applies
  logic [N-1:0]         rarm_q, rarm_d;

  always_comb begin
    rcnt_d = rcnt_q;
    rarm_d = rarm_q;
    rep_ev = '0;
    for (int i = 0; i < N; i++) begin
      if (rise[i] || fall[i]) begin
        rcnt_d[i] = '0;
        rarm_d[i] = 1'b0;
      end else if (level_q[i] && !mode[0]) begin
        if (rcnt_q[i] == (rarm_q[i] ? RW'(REPEAT_PERIOD - 1)
                                    : RW'(REPEAT_DELAY - 1))) begin
          rep_ev[i] = 1'b1;
          rcnt_d[i] = '0;
          rarm_d[i] = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      rarm_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      rarm_q <= rarm_d;
    end
  end
`else
  assign rep_ev = '0;
`endif

  // Edge qualification and pulse FSM; events while ACTIVE are dropped
  always_comb begin
    qev     = '0;
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pulse_d = pulse_q;
    for (int i = 0; i < N; i++) begin
      unique case (mode)
        2'b00:   qev[i] = rise[i];
        2'b01:   qev[i] = fall[i];
        2'b10:   qev[i] = rise[i] | fall[i];
        default: qev[i] = 1'b0;
      endcase
      qev[i] = qev[i] | rep_ev[i];
      unique case (state_q[i])
        IDLE: begin
          if (qev[i]) begin
            state_d[i] = ACTIVE;
            pulse_d[i] = 1'b1;
            pcnt_d[i]  = PW'(PULSE_LEN - 1);
          end
        end
        ACTIVE: begin
          if (pcnt_q[i] != '0) begin
            pcnt_d[i] = pcnt_q[i] - 1'b1;
          end else begin
            pulse_d[i] = 1'b0;
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
    any_d = |pulse_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < N; i++) state_q[i] <= IDLE;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      any_q   <= any_d;
      for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign any_pulse = any_q;

endmodule

// File: tb/tb_multi_oneshot.sv
// tb_multi_oneshot: directed bench for multi_oneshot,
// three instances differing only in PULSE_LEN (1, 3, 5).
module tb_multi_oneshot;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_v = '0;
  logic [1:0] mode = 2'b00;
  logic [3:0] lvl1, pls1, lvl3, pls3, lvl5, pls5;
  logic       any1, any3, any5;
  int         checks = 0;
  int         failures = 0;
  int         h1, h3, h5, lv_or, p_or;

  always #5 clk = ~clk;

  multi_oneshot u_dut (
    .clk(clk), .rst(rst), .in(in_v), .mode(mode),
    .level(lvl1), .pulse(pls1), .any_pulse(any1)
  );

  multi_oneshot #(.PULSE_LEN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in(in_v), .mode(mode),
    .level(lvl3), .pulse(pls3), .any_pulse(any3)
  );

  multi_oneshot #(.PULSE_LEN(5)) u_dut5 (
    .clk(clk), .rst(rst), .in(in_v), .mode(mode),
    .level(lvl5), .pulse(pls5), .any_pulse(any5)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int n, input int ch,
                     output int o1, output int o3, output int o5);
    o1 = 0; o3 = 0; o5 = 0;
    repeat (n) begin
      step(1);
      o1 += int'(pls1[ch]);
      o3 += int'(pls3[ch]);
      o5 += int'(pls5[ch]);
    end
  endtask

  // any_pulse must equal |pulse on every cycle
  always @(negedge clk) begin
    chk("any1_track", {31'd0, any1}, {31'd0, |pls1});
    chk("any5_track", {31'd0, any5}, {31'd0, |pls5});
  end

  initial begin
    // reset state
    step(2);
    chk("rst_level", lvl1, 4'h0);
    chk("rst_pulse", pls1, 4'h0);
    chk("rst_any", any1, 1'b0);

    // basic rising latency, mode 00
    rst = 1'b0;
    in_v = 4'b0001;
    step(5);
    chk("lat_lvl_e5", lvl1, 4'h0);
    chk("lat_pls_e5", pls1, 4'h0);
    step(1);
    chk("lat_lvl_e6", lvl1, 4'b0001);
    chk("lat_pls_e6", pls1, 4'b0001);
    chk("lat_any_e6", any1, 1'b1);
    chk("lat_p3_e6", pls3[0], 1'b1);
    step(1);
    chk("lat_pls_e7", pls1, 4'h0);
    chk("lat_any_e7", any1, 1'b0);
    chk("lat_p3_e7", pls3[0], 1'b1);

    // 3-clock glitch on channel 1
    in_v = 4'b0010;
    lv_or = 0; p_or = 0;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) in_v = 4'b0000;
      step(1);
      lv_or |= int'(lvl1[1]);
      p_or  |= int'(pls1[1]);
    end
    chk("glitch_level", lv_or, 0);
    chk("glitch_pulse", p_or, 0);
    chk("ch0_fell", lvl1[0], 1'b0);

    // both-edge mode, then rising-only
    mode = 2'b10;
    in_v = 4'b0100;
    run(14, 2, h1, h3, h5);
    chk("both_press_p1", h1, 1);
    chk("both_press_p3", h3, 3);
    in_v = 4'b0000;
    run(14, 2, h1, h3, h5);
    chk("both_rel_p1", h1, 1);
    chk("both_rel_p3", h3, 3);
    mode = 2'b00;
    in_v = 4'b0100;
    run(14, 2, h1, h3, h5);
    chk("rise_press_p3", h3, 3);
    in_v = 4'b0000;
    run(14, 2, h1, h3, h5);
    chk("rise_rel_p1", h1, 0);
    chk("rise_rel_p3", h3, 0);
    chk("rise_rel_lvl", lvl3[2], 1'b0);

    // simultaneous channels
    in_v = 4'b1111;
    step(6);
    chk("sim_pulse", pls1, 4'b1111);
    chk("sim_level", lvl1, 4'b1111);
    chk("sim_any", any1, 1'b1);
    step(1);
    chk("sim_pulse_end", pls1, 4'h0);
    in_v = 4'b0000;
    step(10);
    chk("sim_level_off", lvl1, 4'h0);

    // pulses disabled, level still tracks
    mode = 2'b11;
    in_v = 4'b1111;
    p_or = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      p_or |= int'(|pls1) | int'(|pls3);
    end
    chk("m11_pulse", p_or, 0);
    chk("m11_level", lvl1, 4'b1111);

    // reset mid-pulse (PULSE_LEN=5)
    mode = 2'b00;
    in_v = 4'b0000;
    step(10);
    in_v = 4'b0001;
    step(6);
    chk("p5_start", pls5[0], 1'b1);
    step(2);
    chk("p5_mid", pls5[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", pls5, 4'h0);
    chk("mid_rst_level", lvl5, 4'h0);
    chk("mid_rst_any", any5, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(5);
    chk("rel_pls_e5", pls5[0], 1'b0);
    chk("rel_lvl_e5", lvl5[0], 1'b0);
    step(1);
    chk("rel_pls_e6", pls5[0], 1'b1);
    chk("rel_lvl_e6", lvl5[0], 1'b1);
    chk("rel_p1_e6", pls1[0], 1'b1);
    step(4);
    chk("rel_p5_e10", pls5[0], 1'b1);
    step(1);
    chk("rel_p5_e11", pls5[0], 1'b0);

    // long hold: auto-repeat only when built in
    in_v = 4'b0000;
    step(12);
    in_v = 4'b0001;
    step(6);
    chk("hold_first", pls1[0], 1'b1);
    run(60, 0, h1, h3, h5);
`ifdef MULTI_ONESHOT_REPEAT_EN
    chk("hold_repeats", h1 + 1, 7);
`else
    chk("hold_repeats", h1 + 1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_oneshot.md
Name:
multi_oneshot

Overview:
- N-channel debounced edge-to-pulse generator, parametrised in channel count, synchroniser depth, debounce length and pulse width, with a selectable edge mode.
- Each channel passes through three stages: raw asynchronous input, synchroniser, debounced level register, then an edge-qualified pulse of PULSE_LEN clocks.
- Placed between board buttons/switches and control FSMs that need exactly one event per press.

Parameters:
- N, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEB_CYCLES, 4, consecutive mismatch clocks required before the debounced level changes (>=1)
- PULSE_LEN, 1, pulse width in clocks (>=1)
- REPEAT_DELAY, 16, clocks of held level before the first auto-repeat (used only with the optional feature)
- REPEAT_PERIOD, 8, clocks between auto-repeats (used only with the optional feature)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in  input  N  raw asynchronous channel inputs
- mode  input  2  edge select shared by all channels: 00 rising, 01 falling, 10 both, 11 pulses disabled
- level  output  N  debounced level per channel
- pulse  output  N  one-shot pulse per channel, registered
- any_pulse  output  1  OR of pulse, registered

Behaviour:
- Reset: while rst=1, all synchroniser flops, level, pulse, any_pulse and all counters are 0, asynchronously. This applies mid-pulse and mid-debounce.
- Synchroniser: in[i] shifts through SYNC_STAGES flops. s[i] denotes the last stage.
- Debounce, per channel, each clock:
  - if s==level: cnt<=0
  - else if cnt==DEB_CYCLES-1: level<=s, cnt<=0, raise an edge event (rise if s=1, fall if s=0)
  - else: cnt<=cnt+1
  - Any glitch shorter than DEB_CYCLES clocks (after synchronisation) produces no level change and no pulse.
- Latency: input change stable before clk edge 1 means level and pulse change after edge SYNC_STAGES+DEB_CYCLES (defaults: edge 6).
- Qualification: the event starts a pulse if mode=00 and rise, mode=01 and fall, or mode=10 and either edge. mode=11 starts none; level still tracks.
- Pulse FSM per channel, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on a qualified event: pulse<=1, pcnt<=PULSE_LEN-1.
  - ACTIVE: if pcnt!=0, pcnt<=pcnt-1. Else pulse<=0 and return to IDLE.
  - pulse is high for exactly PULSE_LEN clocks.
- Retrigger: a qualified event while ACTIVE is dropped. The pulse is not extended or restarted.
- mode change: sampled at the event cycle only; an in-progress pulse always completes.
- Channel independence: simultaneous events on several channels each produce their own pulse.
- any_pulse is registered in the same cycle as pulse, so any_pulse equals |pulse every cycle.
- Reset release with in held high: level rises after the full latency and a rising pulse is emitted. This is the required behaviour, not a bug.
- Counter widths: clog2 of the respective parameter, minimum 1 bit. Counters saturate-free by construction.

Optional Feature:
- Macro: MULTI_ONESHOT_REPEAT_EN.
- Defined: per channel, a repeat counter rcnt clears on every level change and counts while level=1 and mode is 00 or 10.
  - First repeat event fires REPEAT_DELAY clocks after the level rise, then every REPEAT_PERIOD clocks while held.
  - Each repeat is treated as a qualified event, subject to the same retrigger-drop rule; a dropped repeat does not shift the schedule.
  - mode 01 or 11 suppresses repeats.
- Undefined: no repeat logic is built; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
- Reset, defaults, mode=00: hold in[0]=1 from clock 1 -> level[0]=1 and pulse[0]=1 after edge 6, pulse[0]=0 after edge 7. any_pulse tracks pulse[0].
- Glitch: in[1] high for 3 clocks, DEB_CYCLES=4 -> level[1] and pulse[1] stay 0 throughout.
- PULSE_LEN=3, mode=10: press then release in[2], release 20 clocks later -> two 3-clock pulses, one per edge. Release with mode=00 -> only 1 pulse.
- Simultaneous: in[3:0]=4'b1111 on the same clock -> pulse=4'b1111 for one clock. Then mode=11, repeat the press -> pulse stays 0 while level=4'b1111.
- Reset mid-operation: assert rst during an active PULSE_LEN=5 pulse -> pulse=0 immediately. Release with in held high -> new pulse after 6 edges.
- With MULTI_ONESHOT_REPEAT_EN, defaults: hold in[0] for 60 clocks after level rises -> pulses at level-rise, +16, +24, +32, +40, +48, +56. Without the macro -> a single pulse.
